rapid_muldiv_sequencer: RTL and testbench
=========================================

Name: rapid_muldiv_sequencer

Overview:
- Multi-cycle RV32M multiply/divide unit, sequenced by an FSM, sitting beside the execute-stage ALU.
- Decode/issue hands it M-extension ops over a valid/ready handshake.
- It asserts o_busy so the execute stage stalls, iterates one bit per cycle, and returns the result plus destination register to writeback over a second valid/ready handshake.
- A flush from branch resolution (o_pc_load path) kills any in-flight op.

Parameters:
XLEN, 32, operand/result width; iteration counter is $clog2(XLEN) bits.

Ports:
i_clk  input  1  clock, rising edge
i_rst_n  input  1  asynchronous active-low reset
i_flush  input  1  synchronous kill of in-flight op (branch/jump redirect)
i_valid  input  1  issue request
o_ready  output  1  unit can accept an op (high only in IDLE)
i_funct3  input  3  0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU
i_rs1  input  XLEN  operand A (dividend / multiplicand)
i_rs2  input  XLEN  operand B (divisor / multiplier)
i_rd  input  5  destination register
o_busy  output  1  op in flight (state != IDLE); stalls execute
o_valid  output  1  result available
i_ready  input  1  writeback accepts result
o_result  output  XLEN  result
o_rd  output  5  destination of o_result

Behaviour:
- Reset (async, i_rst_n=0):
  - Outputs: state IDLE; o_valid=0, o_result=0, o_rd=0, o_busy=0, o_ready=1.
  - Internal accumulators and counter cleared.
  - Reset mid-operation abandons the op with no output.
- FSM states: IDLE, CALC, DONE.
- IDLE:
  - Accept when i_valid && o_ready && !i_flush. Latch funct3, rd and operands.
  - Signed ops (DIV, REM, MULH; rs1 only for MULHSU) latch magnitudes plus result-sign flags.
  - Special cases go directly to DONE, so o_valid is high the cycle after the accept:
    - DIV/DIVU with rs2==0: quotient = all-ones.
    - REM/REMU with rs2==0: remainder = rs1.
    - DIV with rs1=0x80000000 and rs2=0xFFFFFFFF: quotient = 0x80000000, REM = 0.
  - All other accepts go to CALC with counter=0.
- CALC:
  - One iteration per cycle, 32 cycles total; counter==XLEN-1 → DONE.
  - Multiply: shift-add on magnitudes into a 2·XLEN product register.
  - Divide: restoring shift-subtract producing quotient and remainder.
  - On the exit edge, apply sign correction (two's complement negate):
    - Product sign = sign(a) XOR sign(b).
    - Quotient sign = sign(a) XOR sign(b).
    - Remainder sign = sign of dividend.
  - Result selection: MUL = low half; MULH/MULHSU/MULHU = high half.
  - Latency: o_valid high exactly XLEN (32) cycles after the accept cycle.
- DONE:
  - o_valid=1; o_result/o_rd held stable while !i_ready.
  - When o_valid && i_ready: → IDLE, o_valid drops next cycle.
  - No new op is accepted in DONE, so back-to-back issue costs one IDLE cycle.
- Flush:
  - i_flush=1 in any state → IDLE next cycle, o_valid=0, result discarded.
  - Flush has priority over accept and over the result handshake in the same cycle.
- rd==0: the op is executed normally and o_rd=0 is presented; writeback discards it.
- o_busy = (state != IDLE); o_ready = (state == IDLE).
- i_valid while busy is ignored. The requester holds it; nothing is queued.

Test Plan:
1. MUL rs1=7, rs2=-3 (0xFFFFFFFD) → o_valid 32 cycles after accept, o_result=0xFFFFFFEB; MULH same operands → 0xFFFFFFFF; MULHU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE.
2. DIV rs1=-20, rs2=3 → 0xFFFFFFFA (-6); REM same operands → 0xFFFFFFFE (-2); DIVU 100/7 → 14; REMU → 2.
3. Special cases, each with o_valid the cycle after accept: DIVU 5/0 → 0xFFFFFFFF; REM 5/0 → 5; DIV 0x80000000/0xFFFFFFFF → 0x80000000; REM same operands → 0.
4. Backpressure: hold i_ready=0 for 10 cycles in DONE → o_valid, o_result, o_rd stable; o_ready=0 throughout; i_ready=1 → IDLE next cycle.
5. Flush: assert i_flush at CALC cycle 15 → IDLE next cycle, no o_valid pulse; next op (MUL 6×7) returns 42 with correct rd. Flush and i_valid in the same IDLE cycle → not accepted.
6. Async reset: pull i_rst_n low mid-CALC, between clock edges → outputs return to reset values immediately; after release, o_ready=1 and a fresh DIV 9/3 returns 3.

Source files
------------

// File: rtl/rapid_muldiv_sequencer.sv
`default_nettype none
// rapid_muldiv_sequencer -- iterative RV32M multiply/divide unit, one bit per cycle.
// Revision 1.0
module rapid_muldiv_sequencer #(
  parameter int XLEN = 32
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_flush,
  input  logic            i_valid,
  output logic            o_ready,
  input  logic [2:0]      i_funct3,
  input  logic [XLEN-1:0] i_rs1,
  input  logic [XLEN-1:0] i_rs2,
  input  logic [4:0]      i_rd,
  output logic            o_busy,
  output logic            o_valid,
  input  logic            i_ready,
  output logic [XLEN-1:0] o_result,
  output logic [4:0]      o_rd
);

  localparam int                c_cnt_w    = $clog2(XLEN);
  localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(XLEN - 1);
  localparam logic [2:0] c_f_mul    = 3'd0;
  localparam logic [2:0] c_f_mulh   = 3'd1;
  localparam logic [2:0] c_f_mulhsu = 3'd2;
  localparam logic [2:0] c_f_div    = 3'd4;
  localparam logic [2:0] c_f_rem    = 3'd6;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             state_q;
  logic [2:0]         funct3_q;
  logic [4:0]         rd_q;
  logic               neg_q;
  logic [XLEN-1:0]    acc_q;
  logic [XLEN-1:0]    lo_q;
  logic [XLEN-1:0]    opb_q;
  logic [c_cnt_w-1:0] cnt_q;
  logic               valid_q;
  logic [XLEN-1:0]    result_q;

  // Issue-side decode: operand magnitudes, result sign and early-exit cases
  logic            w_is_div;
  logic            w_a_neg;
  logic            w_b_neg;
  logic [XLEN-1:0] w_a_mag;
  logic [XLEN-1:0] w_b_mag;
  logic            w_res_neg;
  logic            w_div_zero;
  logic            w_ovf;
  logic [XLEN-1:0] w_special_res;

  always_comb begin
    w_is_div   = i_funct3[2];
    w_a_neg    = i_rs1[XLEN-1] & ((i_funct3 == c_f_mulh) | (i_funct3 == c_f_mulhsu) |
                                  (i_funct3 == c_f_div)  | (i_funct3 == c_f_rem));
    w_b_neg    = i_rs2[XLEN-1] & ((i_funct3 == c_f_mulh) | (i_funct3 == c_f_div) |
                                  (i_funct3 == c_f_rem));
    w_a_mag    = w_a_neg ? -i_rs1 : i_rs1;
    w_b_mag    = w_b_neg ? -i_rs2 : i_rs2;
    w_res_neg  = (i_funct3 == c_f_rem) ? w_a_neg : (w_a_neg ^ w_b_neg);
    w_div_zero = w_is_div && (i_rs2 == '0);
    w_ovf      = ((i_funct3 == c_f_div) || (i_funct3 == c_f_rem)) &&
                 (i_rs1 == {1'b1, {(XLEN-1){1'b0}}}) && (i_rs2 == {XLEN{1'b1}});
    w_special_res = '0;
    if (w_div_zero)
      w_special_res = i_funct3[1] ? i_rs1 : {XLEN{1'b1}};
    else if (w_ovf)
      w_special_res = (i_funct3 == c_f_div) ? {1'b1, {(XLEN-1){1'b0}}} : '0;
  end

  // One iteration step; lo_q holds the multiplier (mul) or the dividend/quotient (div)
  logic [XLEN:0]     w_mul_sum;
  logic [XLEN:0]     w_div_shift;
  logic [XLEN:0]     w_div_diff;
  logic [XLEN-1:0]   w_acc_nx;
  logic [XLEN-1:0]   w_lo_nx;
  logic [2*XLEN-1:0] w_prod_fix;
  logic [XLEN-1:0]   w_div_res;
  logic [XLEN-1:0]   w_final;

  always_comb begin
    w_mul_sum   = {1'b0, acc_q} + (lo_q[0] ? {1'b0, opb_q} : '0);
    w_div_shift = {acc_q, lo_q[XLEN-1]};
    w_div_diff  = w_div_shift - {1'b0, opb_q};
    if (funct3_q[2]) begin
      w_acc_nx = w_div_diff[XLEN] ? w_div_shift[XLEN-1:0] : w_div_diff[XLEN-1:0];
      w_lo_nx  = {lo_q[XLEN-2:0], ~w_div_diff[XLEN]};
    end else begin
      w_acc_nx = w_mul_sum[XLEN:1];
      w_lo_nx  = {w_mul_sum[0], lo_q[XLEN-1:1]};
    end
    w_prod_fix = neg_q ? -{w_acc_nx, w_lo_nx} : {w_acc_nx, w_lo_nx};
    w_div_res  = funct3_q[1] ? w_acc_nx : w_lo_nx;
    if (funct3_q[2])
      w_final = neg_q ? -w_div_res : w_div_res;
    else if (funct3_q == c_f_mul)
      w_final = w_prod_fix[XLEN-1:0];
    else
      w_final = w_prod_fix[2*XLEN-1:XLEN];
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= S_IDLE;
      funct3_q <= '0;
      rd_q     <= '0;
      neg_q    <= 1'b0;
      acc_q    <= '0;
      lo_q     <= '0;
      opb_q    <= '0;
      cnt_q    <= '0;
      valid_q  <= 1'b0;
      result_q <= '0;
    end else if (i_flush) begin
      state_q <= S_IDLE;
      valid_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (i_valid) begin
            funct3_q <= i_funct3;
            rd_q     <= i_rd;
            neg_q    <= w_res_neg;
            acc_q    <= '0;
            lo_q     <= w_is_div ? w_a_mag : w_b_mag;
            opb_q    <= w_is_div ? w_b_mag : w_a_mag;
            cnt_q    <= '0;
            if (w_div_zero || w_ovf) begin
              result_q <= w_special_res;
              valid_q  <= 1'b1;
              state_q  <= S_DONE;
            end else begin
              state_q <= S_CALC;
            end
          end
        end
        S_CALC: begin
          acc_q <= w_acc_nx;
          lo_q  <= w_lo_nx;
          cnt_q <= cnt_q + c_cnt_w'(1);
          if (cnt_q == c_cnt_last) begin
            result_q <= w_final;
            valid_q  <= 1'b1;
            state_q  <= S_DONE;
          end
        end
        S_DONE: begin
          if (i_ready) begin
            valid_q <= 1'b0;
            state_q <= S_IDLE;
          end
        end
        default: begin
          state_q <= S_IDLE;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign o_busy   = (state_q != S_IDLE);
  assign o_ready  = (state_q == S_IDLE);
  assign o_valid  = valid_q;
  assign o_result = result_q;
  assign o_rd     = rd_q;

endmodule
`default_nettype wire

// File: tb/tb_rapid_muldiv_sequencer.sv
`default_nettype none
// tb_rapid_muldiv_sequencer -- directed vector table, corner sequences and random ops vs. arithmetic model.
// Revision 1.0
module tb_rapid_muldiv_sequencer;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        out_ready;
  logic [2:0]  funct3;
  logic [31:0] rs1;
  logic [31:0] rs2;
  logic [4:0]  rd;
  logic        busy;
  logic        out_valid;
  logic        wb_ready;
  logic [31:0] result;
  logic [4:0]  out_rd;

  int errors = 0;
  int checks = 0;

  rapid_muldiv_sequencer #(.XLEN(32)) dut (
    .i_clk    (clk),
    .i_rst_n  (rst_n),
    .i_flush  (flush),
    .i_valid  (in_valid),
    .o_ready  (out_ready),
    .i_funct3 (funct3),
    .i_rs1    (rs1),
    .i_rs2    (rs2),
    .i_rd     (rd),
    .o_busy   (busy),
    .o_valid  (out_valid),
    .i_ready  (wb_ready),
    .o_result (result),
    .o_rd     (out_rd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  f;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  vec_t vecs[16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Reference model: RV32M semantics from plain integer arithmetic
  function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    int          sa;
    int          sb;
    longint      ps;
    logic [63:0] p;
    sa = a;
    sb = b;
    case (f)
      3'd0: begin p = {32'b0, a} * {32'b0, b}; return p[31:0]; end
      3'd1: begin ps = longint'(sa) * longint'(sb); p = ps; return p[63:32]; end
      3'd2: begin ps = longint'(sa) * longint'({32'b0, b}); p = ps; return p[63:32]; end
      3'd3: begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        return 32'(sa / sb);
      end
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
        return 32'(sa % sb);
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int model_lat(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    if (f[2] && b == 0) return 0;
    if ((f == 3'd4 || f == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 0;
    return 32;
  endfunction

  // Presents an op for one cycle; returns at the negedge after the accept edge
  task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b, input logic [4:0] d);
    @(negedge clk);
    chk("ready_before_issue", {31'b0, out_ready}, 32'd1);
    funct3   = f;
    rs1      = a;
    rs2      = b;
    rd       = d;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Edges after the accept edge until o_valid is seen (bounded)
  task automatic wait_valid(output int lat);
    lat = 0;
    while (!out_valid && lat < 100) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic run_op(input string name, input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] d, input logic [31:0] exp, input int exp_lat);
    int lat;
    issue(f, a, b, d);
    wait_valid(lat);
    chk({name, "_latency"}, lat, exp_lat);
    chk({name, "_result"}, result, exp);
    chk({name, "_rd"}, {27'b0, out_rd}, {27'b0, d});
    @(negedge clk);
    chk({name, "_valid_drop"}, {31'b0, out_valid}, 32'd0);
  endtask

  initial begin
    int lat;
    logic [2:0]  rf;
    logic [31:0] ra;
    logic [31:0] rb;
    logic [4:0]  rr;
    logic [31:0] hold_res;

    vecs[0]  = '{3'd0, 32'd7,          32'hFFFF_FFFD, 5'd1,  32'hFFFF_FFEB, 32};
    vecs[1]  = '{3'd1, 32'd7,          32'hFFFF_FFFD, 5'd2,  32'hFFFF_FFFF, 32};
    vecs[2]  = '{3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 5'd3,  32'hFFFF_FFFE, 32};
    vecs[3]  = '{3'd2, 32'hFFFF_FFFF,  32'd2,         5'd4,  32'hFFFF_FFFF, 32};
    vecs[4]  = '{3'd4, 32'hFFFF_FFEC,  32'd3,         5'd5,  32'hFFFF_FFFA, 32};
    vecs[5]  = '{3'd6, 32'hFFFF_FFEC,  32'd3,         5'd6,  32'hFFFF_FFFE, 32};
    vecs[6]  = '{3'd5, 32'd100,        32'd7,         5'd7,  32'd14,        32};
    vecs[7]  = '{3'd7, 32'd100,        32'd7,         5'd8,  32'd2,         32};
    vecs[8]  = '{3'd4, 32'd20,         32'hFFFF_FFFD, 5'd9,  32'hFFFF_FFFA, 32};
    vecs[9]  = '{3'd6, 32'd20,         32'hFFFF_FFFD, 5'd10, 32'd2,         32};
    vecs[10] = '{3'd5, 32'd5,          32'd0,         5'd11, 32'hFFFF_FFFF, 0};
    vecs[11] = '{3'd6, 32'd5,          32'd0,         5'd12, 32'd5,         0};
    vecs[12] = '{3'd4, 32'h8000_0000,  32'hFFFF_FFFF, 5'd13, 32'h8000_0000, 0};
    vecs[13] = '{3'd6, 32'h8000_0000,  32'hFFFF_FFFF, 5'd14, 32'd0,         0};
    vecs[14] = '{3'd0, 32'd3,          32'd4,         5'd0,  32'd12,        32};
    vecs[15] = '{3'd3, 32'h8000_0000,  32'd2,         5'd31, 32'd1,         32};

    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; wb_ready = 1'b1;
    funct3 = '0; rs1 = '0; rs2 = '0; rd = '0;
    repeat (3) @(negedge clk);
    chk("reset_valid",  {31'b0, out_valid}, 32'd0);
    chk("reset_ready",  {31'b0, out_ready}, 32'd1);
    chk("reset_busy",   {31'b0, busy}, 32'd0);
    chk("reset_result", result, 32'd0);
    chk("reset_rd",     {27'b0, out_rd}, 32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 16; i++)
      run_op($sformatf("vec%0d", i), vecs[i].f, vecs[i].a, vecs[i].b, vecs[i].rd, vecs[i].exp, vecs[i].lat);

    // Backpressure in DONE
    wb_ready = 1'b0;
    issue(3'd0, 32'd11, 32'd13, 5'd17);
    wait_valid(lat);
    chk("bp_latency", lat, 32);
    chk("bp_result", result, 32'd143);
    hold_res = result;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("bp_valid_held", {31'b0, out_valid}, 32'd1);
      chk("bp_result_held", result, hold_res);
      chk("bp_rd_held", {27'b0, out_rd}, 32'd17);
      chk("bp_ready_low", {31'b0, out_ready}, 32'd0);
    end
    wb_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_valid", {31'b0, out_valid}, 32'd0);
    chk("bp_release_ready", {31'b0, out_ready}, 32'd1);

    // Flush at CALC cycle 15
    issue(3'd5, 32'd1000, 32'd7, 5'd20);
    repeat (15) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("flush_ready", {31'b0, out_ready}, 32'd1);
    chk("flush_busy", {31'b0, busy}, 32'd0);
    lat = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (out_valid) lat++;
    end
    chk("flush_no_valid", lat, 0);
    run_op("after_flush", 3'd0, 32'd6, 32'd7, 5'd21, 32'd42, 32);

    // Flush and issue in the same IDLE cycle
    @(negedge clk);
    funct3 = 3'd0; rs1 = 32'd2; rs2 = 32'd2; rd = 5'd3;
    in_valid = 1'b1; flush = 1'b1;
    @(negedge clk);
    in_valid = 1'b0; flush = 1'b0;
    chk("flush_issue_ready", {31'b0, out_ready}, 32'd1);
    chk("flush_issue_busy", {31'b0, busy}, 32'd0);

    // Async reset mid-CALC, between clock edges
    issue(3'd0, 32'd123, 32'd456, 5'd9);
    repeat (10) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("areset_busy", {31'b0, busy}, 32'd0);
    chk("areset_ready", {31'b0, out_ready}, 32'd1);
    chk("areset_valid", {31'b0, out_valid}, 32'd0);
    chk("areset_result", result, 32'd0);
    chk("areset_rd", {27'b0, out_rd}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_op("after_reset", 3'd4, 32'd9, 32'd3, 5'd5, 32'd3, 32);

    // Randomized ops against the model
    for (int i = 0; i < 40; i++) begin
      rf = 3'($urandom_range(0, 7));
      ra = $urandom;
      rb = $urandom;
      rr = 5'($urandom_range(0, 31));
      case ($urandom_range(0, 9))
        0: rb = 32'd0;
        1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
        2: begin ra = 32'($urandom_range(0, 1000)); rb = 32'($urandom_range(1, 50)); end
        3: rb = -32'($urandom_range(1, 50));
        default: ;
      endcase
      run_op($sformatf("rnd%0d_f%0d", i, rf), rf, ra, rb, rr, model(rf, ra, rb), model_lat(rf, ra, rb));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
